// File: rtl/ascon_bdi_packer_pkg.sv
// ============================================================================
// Module   : ascon_bdi_packer_pkg
// Brief    : Shared types, width defaults and byte-mask helper for the packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ascon_bdi_packer_pkg;

  localparam int CCW_DEFAULT = 32;

  typedef enum logic [2:0] {
    D_INVALID = 3'd0,
    D_NONCE   = 3'd1,
    D_AD      = 3'd2,
    D_MSG     = 3'd3,
    D_TAG     = 3'd4
  } data_e;

  // Mask with bits [cnt:0] set; callers slice the low NB bits.
  function automatic logic [7:0] byte_mask(input logic [2:0] cnt);
    logic [8:0] m;
    m = (9'd2 << cnt) - 9'd1;
    return m[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ascon_bdi_packer_if.sv
// ============================================================================
// Module   : ascon_bdi_packer_if
// Brief    : Byte-in / word-out bus bundle between a byte source and the core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ascon_bdi_packer_if
  import ascon_bdi_packer_pkg::*;
#(
  parameter int CCW = CCW_DEFAULT
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  data_e            in_type;
  logic             in_last;
  logic             in_eoi;
  logic [CCW-1:0]   bdi;
  logic [CCW/8-1:0] bdi_valid;
  logic             bdi_ready;
  data_e            bdi_type;
  logic             bdi_eot;
  logic             bdi_eoi;

  modport master (
    output in_data, in_valid, in_type, in_last, in_eoi, bdi_ready,
    input  in_ready, bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi
  );

  modport slave (
    input  in_data, in_valid, in_type, in_last, in_eoi, bdi_ready,
    output in_ready, bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi
  );
endinterface

`default_nettype wire

// File: rtl/ascon_bdi_outbuf.sv
// ============================================================================
// Module   : ascon_bdi_outbuf
// Brief    : Output stage holding {word, mask, type, eot, eoi}; single register
//            by default, 2-entry in-order FIFO when ASCON_PACKER_SKID_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_bdi_outbuf
  import ascon_bdi_packer_pkg::*;
#(
  parameter int CCW = CCW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [CCW-1:0]   push_word,
  input  logic [CCW/8-1:0] push_mask,
  input  data_e            push_type,
  input  logic             push_eot,
  input  logic             push_eoi,
  input  logic             pop_ready,
  output logic [CCW-1:0]   out_word,
  output logic [CCW/8-1:0] out_mask,
  output data_e            out_type,
  output logic             out_eot,
  output logic             out_eoi,
  output logic             can_accept
);

  localparam int NB = CCW / 8;
  localparam int TW = $bits(data_e);
  localparam int PW = CCW + NB + TW + 2;
  localparam logic [PW-1:0] EMPTY_PL = {{CCW{1'b0}}, {NB{1'b0}}, D_INVALID, 2'b00};

  logic [PW-1:0] w_push_pl;
  logic [PW-1:0] head_q, head_d;
  logic [1:0]    count_q, count_d;
  logic          w_pop;

  assign w_push_pl = {push_word, push_mask, push_type, push_eot, push_eoi};
  assign w_pop     = (count_q != 2'd0) && pop_ready;

  assign out_word = head_q[PW-1 -: CCW];
  assign out_mask = head_q[TW+2 +: NB];
  assign out_type = data_e'(head_q[2 +: TW]);
  assign out_eot  = head_q[1];
  assign out_eoi  = head_q[0];

`ifdef ASCON_PACKER_SKID_EN
  logic [PW-1:0] skid_q, skid_d;
  logic          ready_q, ready_d;

  always_comb begin
    head_d  = head_q;
    skid_d  = skid_q;
    count_d = count_q;
    case ({w_pop, push})
      2'b10: begin
        if (count_q == 2'd2) begin
          head_d  = skid_q;
          skid_d  = EMPTY_PL;
          count_d = 2'd1;
        end else begin
          head_d  = EMPTY_PL;
          count_d = 2'd0;
        end
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          head_d = skid_q;
          skid_d = w_push_pl;
        end else begin
          head_d = w_push_pl;
        end
      end
      2'b01: begin
        if (count_q == 2'd0) begin
          head_d  = w_push_pl;
          count_d = 2'd1;
        end else begin
          skid_d  = w_push_pl;
          count_d = 2'd2;
        end
      end
      default: ;
    endcase
    // Registered ready: looks at the next occupancy, never at pop_ready directly.
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= EMPTY_PL;
      skid_q  <= EMPTY_PL;
      count_q <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      skid_q  <= skid_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  assign can_accept = ready_q;
`else
  always_comb begin
    head_d  = head_q;
    count_d = count_q;
    if (push) begin
      head_d  = w_push_pl;
      count_d = 2'd1;
    end else if (w_pop) begin
      head_d  = EMPTY_PL;
      count_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= EMPTY_PL;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  assign can_accept = (count_q == 2'd0) || pop_ready;
`endif

endmodule

`default_nettype wire

// File: rtl/ascon_bdi_packer.sv
// ============================================================================
// Module   : ascon_bdi_packer
// Brief    : Packs a typed byte stream into CCW-bit masked words for ascon_core.
//            Macro ASCON_PACKER_SKID_EN selects a 2-entry registered-ready stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_bdi_packer
  import ascon_bdi_packer_pkg::*;
#(
  parameter int CCW = CCW_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  ascon_bdi_packer_if.slave   bus,
  output logic                proto_err
);

  localparam int NB = CCW / 8;
  localparam int CW = $clog2(NB);

  logic [CCW-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  data_e          acc_type_q, acc_type_d;
  logic           seg_open_q, seg_open_d;
  logic           proto_err_q, proto_err_d;

  logic           w_accept;
  logic           w_push;
  logic [CCW-1:0] w_word;
  logic [7:0]     w_mask8;
  logic [NB-1:0]  w_mask;
  data_e          w_type;
  logic           w_can_accept;

  assign w_accept  = bus.in_valid && w_can_accept;
  assign bus.in_ready = w_can_accept;
  assign proto_err = proto_err_q;

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    acc_type_d  = acc_type_q;
    seg_open_d  = seg_open_q;
    proto_err_d = proto_err_q;
    w_push      = 1'b0;
    w_word      = acc_q;
    w_word[8*cnt_q +: 8] = bus.in_data;
    w_mask8     = byte_mask(3'(cnt_q));
    w_mask      = w_mask8[NB-1:0];
    // Once a segment is open its type is fixed; a mismatching byte keeps it.
    w_type      = seg_open_q ? acc_type_q : bus.in_type;
    if (w_accept) begin
      seg_open_d = 1'b1;
      if (!seg_open_q) begin
        acc_type_d = bus.in_type;
      end
      if ((seg_open_q && (bus.in_type != acc_type_q)) || (bus.in_eoi && !bus.in_last)) begin
        proto_err_d = 1'b1;
      end
      if ((cnt_q == CW'(NB - 1)) || bus.in_last) begin
        w_push = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
        if (bus.in_last) begin
          seg_open_d = 1'b0;
        end
      end else begin
        acc_d = w_word;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      acc_type_q  <= D_INVALID;
      seg_open_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      acc_type_q  <= acc_type_d;
      seg_open_q  <= seg_open_d;
      proto_err_q <= proto_err_d;
    end
  end

  ascon_bdi_outbuf #(
    .CCW (CCW)
  ) u_outbuf (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .push_word  (w_word),
    .push_mask  (w_mask),
    .push_type  (w_type),
    .push_eot   (bus.in_last),
    .push_eoi   (bus.in_eoi && bus.in_last),
    .pop_ready  (bus.bdi_ready),
    .out_word   (bus.bdi),
    .out_mask   (bus.bdi_valid),
    .out_type   (bus.bdi_type),
    .out_eot    (bus.bdi_eot),
    .out_eoi    (bus.bdi_eoi),
    .can_accept (w_can_accept)
  );

endmodule

`default_nettype wire
